// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared pipeline constants and helpers for the memory stage.
//   - bus widths for registers, register addresses and instruction types
//   - load/store instruction type codes
//   - pipeline idle values (zero word, NOP register, write disable, stall flags)
//   - classification helpers used by the stage FSM
package mem_stage_pkg;

  localparam int REG_W       = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int INST_TYPE_W = 6;

  typedef logic [INST_TYPE_W-1:0] inst_type_t;

  // Load/store type codes; every other code is a non-memory instruction.
  localparam inst_type_t INST_LB  = 6'h10;
  localparam inst_type_t INST_LH  = 6'h11;
  localparam inst_type_t INST_LW  = 6'h12;
  localparam inst_type_t INST_LBU = 6'h13;
  localparam inst_type_t INST_LHU = 6'h14;
  localparam inst_type_t INST_SB  = 6'h18;
  localparam inst_type_t INST_SH  = 6'h19;
  localparam inst_type_t INST_SW  = 6'h1A;

  localparam logic [REG_W-1:0]      ZERO_WORD     = '0;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;
  localparam logic                  WRITE_DISABLE = 1'b0;
  localparam logic                  STOP          = 1'b1;
  localparam logic                  NOT_STOP      = 1'b0;

  function automatic logic is_load(input inst_type_t t);
    return (t == INST_LB) || (t == INST_LH) || (t == INST_LW) ||
           (t == INST_LBU) || (t == INST_LHU);
  endfunction

  function automatic logic is_store(input inst_type_t t);
    return (t == INST_SB) || (t == INST_SH) || (t == INST_SW);
  endfunction

  // Index of the last byte of the access (byte count minus one).
  function automatic logic [1:0] last_byte_idx(input inst_type_t t);
    case (t)
      INST_LH, INST_LHU, INST_SH: return 2'd1;
      INST_LW, INST_SW:           return 2'd3;
      default:                    return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: shared 8-bit RAM port between the memory stage and the arbiter.
//   mem_req_out  stage requests the port
//   mem_a_out    byte address
//   mem_wr_out   1 = write, 0 = read
//   mem_dout     write data
//   mem_grant_in arbiter grants the port this cycle
//   mem_din      read data, valid one cycle after the address is issued
// master = memory stage side, slave = arbiter/RAM side.
interface mem_stage_if #(
  parameter int ADDR_W = 32
) ();

  logic              mem_req_out;
  logic [ADDR_W-1:0] mem_a_out;
  logic              mem_wr_out;
  logic [7:0]        mem_dout;
  logic              mem_grant_in;
  logic [7:0]        mem_din;

  modport master (
    output mem_req_out, mem_a_out, mem_wr_out, mem_dout,
    input  mem_grant_in, mem_din
  );

  modport slave (
    input  mem_req_out, mem_a_out, mem_wr_out, mem_dout,
    output mem_grant_in, mem_din
  );

endinterface

// File: rtl/mem_stage_load_ext.sv
// mem_load_ext: combinational extension of the assembled load buffer.
//   inst_type_in  load type (LB/LH sign-extend, LBU/LHU zero-extend, LW as is)
//   data_in       little-endian bytes collected from RAM
//   val_out       32-bit write-back value
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  inst_type_t         inst_type_in,
  input  logic [REG_W-1:0]   data_in,
  output logic [REG_W-1:0]   val_out
);

  always_comb begin
    val_out = data_in;
    case (inst_type_in)
      INST_LB:  val_out = {{24{data_in[7]}}, data_in[7:0]};
      INST_LBU: val_out = {24'h0, data_in[7:0]};
      INST_LH:  val_out = {{16{data_in[15]}}, data_in[15:0]};
      INST_LHU: val_out = {16'h0, data_in[15:0]};
      default:  val_out = data_in;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the in-order RV32I pipeline.
// Loads and stores move one byte per granted cycle over the shared 8-bit RAM
// port; the pipeline is held through stall_req_out until the access is done.
// Non-memory instructions pass straight through with no stall.
//   clk_in, rst_in         clock, synchronous active-high reset
//   *_mem_in               instruction fields from ex_mem (held while stalled)
//   mem_bus (master)       RAM port: req/addr/wr/dout out, grant/din in
//   rd_out/rd_addr_out/
//   rd_val_out             write-back fields to mem_wb
//   stall_req_out          stall request to ctrl
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rd_mem_in,
  input  logic [REG_ADDR_W-1:0]  rd_addr_mem_in,
  input  logic [REG_W-1:0]       rd_val_mem_in,
  input  inst_type_t             inst_type_mem_in,
  input  logic [ADDR_W-1:0]      mem_addr_mem_in,
  input  logic [REG_W-1:0]       store_val_mem_in,
  mem_stage_if.master            mem_bus,
  output logic                   rd_out,
  output logic [REG_ADDR_W-1:0]  rd_addr_out,
  output logic [REG_W-1:0]       rd_val_out,
  output logic                   stall_req_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state;
  logic [1:0]       idx;
  logic             pend;
  logic [1:0]       pend_lane;
  logic [REG_W-1:0] data_buf;
  logic [REG_W-1:0] ext_val;

  logic       is_ld;
  logic       is_st;
  logic       is_mem;
  logic [1:0] last_idx;
  logic       issue;

  assign is_ld    = is_load(inst_type_mem_in);
  assign is_st    = is_store(inst_type_mem_in);
  assign is_mem   = is_ld | is_st;
  assign last_idx = last_byte_idx(inst_type_mem_in);
  assign issue    = (state == S_ACCESS) && mem_bus.mem_grant_in;

  mem_load_ext u_load_ext (
    .inst_type_in (inst_type_mem_in),
    .data_in      (data_buf),
    .val_out      (ext_val)
  );

  // Sequencer. A read byte issued in one cycle arrives on mem_din in the next,
  // so the issuing lane is remembered in pend_lane and written into data_buf
  // one edge later whatever the grant is then. Reset drops any pending read.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      pend      <= 1'b0;
      pend_lane <= 2'd0;
      data_buf  <= '0;
    end else begin
      if (pend) begin
        data_buf[{pend_lane, 3'b000} +: 8] <= mem_bus.mem_din;
      end
      pend <= issue && is_ld;
      if (issue) begin
        pend_lane <= idx;
      end

      case (state)
        S_IDLE: begin
          if (is_mem) begin
            state <= S_ACCESS;
            idx   <= 2'd0;
          end
        end
        S_ACCESS: begin
          if (issue) begin
            idx <= idx + 2'd1;
            if (idx == last_idx) begin
              state <= is_ld ? S_WAIT : S_DONE;
            end
          end
        end
        S_WAIT:  state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode. Everything is forced to its idle value while reset is held;
  // during the stall the write-back fields carry a bubble so mem_wb never sees
  // a half-finished load.
  always_comb begin
    rd_out              = WRITE_DISABLE;
    rd_addr_out         = NOP_REG_ADDR;
    rd_val_out          = ZERO_WORD;
    stall_req_out       = NOT_STOP;
    mem_bus.mem_req_out = 1'b0;
    mem_bus.mem_a_out   = '0;
    mem_bus.mem_wr_out  = 1'b0;
    mem_bus.mem_dout    = 8'h00;
    if (!rst_in) begin
      case (state)
        S_IDLE: begin
          if (is_mem) begin
            stall_req_out = STOP;
          end else begin
            rd_out      = rd_mem_in;
            rd_addr_out = rd_addr_mem_in;
            rd_val_out  = rd_val_mem_in;
          end
        end
        S_ACCESS: begin
          stall_req_out       = STOP;
          mem_bus.mem_req_out = 1'b1;
          mem_bus.mem_a_out   = mem_addr_mem_in + {{(ADDR_W-2){1'b0}}, idx};
          if (issue && is_st) begin
            mem_bus.mem_wr_out = 1'b1;
            mem_bus.mem_dout   = store_val_mem_in[{idx, 3'b000} +: 8];
          end
        end
        S_WAIT: begin
          stall_req_out = STOP;
        end
        S_DONE: begin
          rd_addr_out = rd_addr_mem_in;
          rd_out      = is_st ? WRITE_DISABLE : rd_mem_in;
          rd_val_out  = is_ld ? ext_val : rd_val_mem_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized bench for mem_stage with a byte-array
// RAM device and a transaction-level model of the expected behaviour.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rd_mem_in;
  logic [4:0]  rd_addr_mem_in;
  logic [31:0] rd_val_mem_in;
  inst_type_t  inst_type_mem_in;
  logic [31:0] mem_addr_mem_in;
  logic [31:0] store_val_mem_in;
  logic        rd_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_val_out;
  logic        stall_req_out;

  localparam inst_type_t T_ADD = 6'h01;
  localparam inst_type_t T_SUB = 6'h02;
  localparam inst_type_t T_XOR = 6'h05;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] ram [0:1023];

  mem_stage_if #(.ADDR_W(32)) bus ();

  mem_stage #(.ADDR_W(32)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rd_mem_in        (rd_mem_in),
    .rd_addr_mem_in   (rd_addr_mem_in),
    .rd_val_mem_in    (rd_val_mem_in),
    .inst_type_mem_in (inst_type_mem_in),
    .mem_addr_mem_in  (mem_addr_mem_in),
    .store_val_mem_in (store_val_mem_in),
    .mem_bus          (bus),
    .rd_out           (rd_out),
    .rd_addr_out      (rd_addr_out),
    .rd_val_out       (rd_val_out),
    .stall_req_out    (stall_req_out)
  );

  always #5 clk_in = ~clk_in;

  // RAM device: granted reads return data on the following cycle, anything
  // else leaves random junk on mem_din.
  always @(posedge clk_in) begin
    if (bus.mem_req_out && bus.mem_grant_in && !bus.mem_wr_out)
      bus.mem_din <= ram[bus.mem_a_out[9:0]];
    else
      bus.mem_din <= 8'($urandom);
    if (bus.mem_req_out && bus.mem_grant_in && bus.mem_wr_out)
      ram[bus.mem_a_out[9:0]] = bus.mem_dout;
  end

  function automatic int nBytes(input inst_type_t t);
    case (t)
      INST_LB, INST_LBU, INST_SB: return 1;
      INST_LH, INST_LHU, INST_SH: return 2;
      INST_LW, INST_SW:           return 4;
      default:                    return 0;
    endcase
  endfunction

  function automatic bit isStoreOp(input inst_type_t t);
    return (t == INST_SB) || (t == INST_SH) || (t == INST_SW);
  endfunction

  function automatic logic [31:0] loadValue(input inst_type_t t, input logic [31:0] addr);
    logic [31:0] raw;
    raw = 32'h0;
    for (int j = 0; j < nBytes(t); j++)
      raw = raw | (32'(ram[10'(addr + 32'(j))]) << (8 * j));
    case (t)
      INST_LB: return 32'($signed(raw[7:0]));
      INST_LH: return 32'($signed(raw[15:0]));
      default: return raw;
    endcase
  endfunction

  task automatic applyStimulus(input logic rst, input logic rd, input logic [4:0] rda,
                               input logic [31:0] rdv, input inst_type_t t,
                               input logic [31:0] addr, input logic [31:0] sval,
                               input logic g);
    rst_in           = rst;
    rd_mem_in        = rd;
    rd_addr_mem_in   = rda;
    rd_val_mem_in    = rdv;
    inst_type_mem_in = t;
    mem_addr_mem_in  = addr;
    store_val_mem_in = sval;
    bus.mem_grant_in = g;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // One instruction from presentation to completion. Starts and ends on a
  // negedge. Grants are denied for denyCnt cycles once denyFrom bytes are out;
  // otherwise grants are constant or random.
  task automatic runOp(input inst_type_t t, input logic [31:0] addr, input logic [31:0] sval,
                       input logic [31:0] rdv, input logic [4:0] rda,
                       input int denyFrom, input int denyCnt, input bit randGrant,
                       input bit useExp, input logic [31:0] expVal);
    int  n;
    int  k;
    int  denied;
    int  cycles;
    bit  st;
    logic g;
    n  = nBytes(t);
    st = isStoreOp(t);
    applyStimulus(1'b0, 1'b1, rda, rdv, t, addr, sval, 1'($urandom));
    #1;
    if (n == 0) begin
      checkOutput("pass_rd", 32'(rd_out), 32'd1);
      checkOutput("pass_rd_addr", 32'(rd_addr_out), 32'(rda));
      checkOutput("pass_rd_val", rd_val_out, rdv);
      checkOutput("pass_stall", 32'(stall_req_out), 32'd0);
      checkOutput("pass_req", 32'(bus.mem_req_out), 32'd0);
      checkOutput("pass_addr", bus.mem_a_out, 32'd0);
      @(negedge clk_in);
      return;
    end
    checkOutput("idle_stall", 32'(stall_req_out), 32'd1);
    checkOutput("idle_req", 32'(bus.mem_req_out), 32'd0);
    checkOutput("idle_rd", 32'(rd_out), 32'd0);
    @(negedge clk_in);
    k = 0;
    denied = 0;
    cycles = 0;
    while (k < n) begin
      if (cycles >= 64) begin
        checkOutput("access_timeout", 32'(k), 32'(n));
        break;
      end
      if (k == denyFrom && denied < denyCnt) begin
        g = 1'b0;
        denied++;
      end else if (randGrant) begin
        g = ($urandom_range(0, 3) != 0);
      end else begin
        g = 1'b1;
      end
      bus.mem_grant_in = g;
      #1;
      checkOutput("access_req", 32'(bus.mem_req_out), 32'd1);
      checkOutput("access_stall", 32'(stall_req_out), 32'd1);
      checkOutput("access_wr", 32'(bus.mem_wr_out), 32'(g && st));
      if (g) begin
        checkOutput("access_addr", bus.mem_a_out, addr + 32'(k));
        if (st) checkOutput("access_dout", 32'(bus.mem_dout), 32'(sval[8*k +: 8]));
        k++;
      end
      cycles++;
      @(negedge clk_in);
    end
    if (!st) begin
      bus.mem_grant_in = 1'($urandom);
      #1;
      checkOutput("wait_stall", 32'(stall_req_out), 32'd1);
      checkOutput("wait_req", 32'(bus.mem_req_out), 32'd0);
      checkOutput("wait_addr", bus.mem_a_out, 32'd0);
      @(negedge clk_in);
    end
    bus.mem_grant_in = 1'($urandom);
    #1;
    checkOutput("done_stall", 32'(stall_req_out), 32'd0);
    checkOutput("done_req", 32'(bus.mem_req_out), 32'd0);
    checkOutput("done_rd", 32'(rd_out), st ? 32'd0 : 32'd1);
    checkOutput("done_rd_addr", 32'(rd_addr_out), 32'(rda));
    if (!st) checkOutput("done_load_val", rd_val_out, useExp ? expVal : loadValue(t, addr));
    if (st) begin
      for (int j = 0; j < n; j++)
        checkOutput("store_ram_byte", 32'(ram[10'(addr + 32'(j))]), 32'(sval[8*j +: 8]));
    end
    @(negedge clk_in);
  endtask

  initial begin
    inst_type_t kinds [11];
    inst_type_t t;
    kinds = '{INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU,
              INST_SB, INST_SH, INST_SW, T_ADD, T_SUB, T_XOR};
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    ram[10'h100] = 8'h78; ram[10'h101] = 8'h56;
    ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
    ram[10'h080] = 8'h80;
    ram[10'h040] = 8'hFE; ram[10'h041] = 8'hFF;

    // Reset held with a live ADD on the inputs: everything reads as zero.
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h0000_1234, T_ADD, 32'h0, 32'h0, 1'b1);
    @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("reset_rd", 32'(rd_out), 32'd0);
    checkOutput("reset_rd_addr", 32'(rd_addr_out), 32'd0);
    checkOutput("reset_rd_val", rd_val_out, 32'd0);
    checkOutput("reset_stall", 32'(stall_req_out), 32'd0);
    checkOutput("reset_req", 32'(bus.mem_req_out), 32'd0);
    @(negedge clk_in);

    $display("[TB] directed sequence");
    runOp(T_ADD, 32'h0, 32'h0, 32'h5, 5'd3, -1, 0, 1'b0, 1'b0, 32'h0);
    runOp(INST_LW, 32'h100, 32'h0, 32'h0, 5'd10, -1, 0, 1'b0, 1'b1, 32'h1234_5678);
    runOp(T_ADD, 32'h0, 32'h0, 32'h0000_A5A5, 5'd4, -1, 0, 1'b0, 1'b0, 32'h0);
    runOp(INST_LB, 32'h80, 32'h0, 32'h0, 5'd11, -1, 0, 1'b0, 1'b1, 32'hFFFF_FF80);
    runOp(INST_LBU, 32'h80, 32'h0, 32'h0, 5'd12, -1, 0, 1'b0, 1'b1, 32'h0000_0080);
    runOp(INST_LH, 32'h40, 32'h0, 32'h0, 5'd13, -1, 0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    runOp(INST_SH, 32'h200, 32'h0000_BEEF, 32'h0, 5'd14, -1, 0, 1'b0, 1'b0, 32'h0);
    checkOutput("sh_byte0", 32'(ram[10'h200]), 32'h0000_00EF);
    checkOutput("sh_byte1", 32'(ram[10'h201]), 32'h0000_00BE);
    runOp(INST_LW, 32'h100, 32'h0, 32'h0, 5'd15, 2, 2, 1'b0, 1'b1, 32'h1234_5678);

    // Reset in the middle of an LW, after two bytes have gone out.
    applyStimulus(1'b0, 1'b1, 5'd16, 32'h0, INST_LW, 32'h300, 32'h0, 1'b1);
    @(negedge clk_in);
    @(negedge clk_in);
    @(negedge clk_in);
    applyStimulus(1'b1, 1'b1, 5'd7, 32'h0000_CAFE, T_ADD, 32'h0, 32'h0, 1'b1);
    #1;
    checkOutput("midreset_rd", 32'(rd_out), 32'd0);
    checkOutput("midreset_rd_val", rd_val_out, 32'd0);
    checkOutput("midreset_stall", 32'(stall_req_out), 32'd0);
    checkOutput("midreset_req", 32'(bus.mem_req_out), 32'd0);
    checkOutput("midreset_wr", 32'(bus.mem_wr_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    checkOutput("postreset_req", 32'(bus.mem_req_out), 32'd0);
    checkOutput("postreset_stall", 32'(stall_req_out), 32'd0);
    checkOutput("postreset_rd_val", rd_val_out, 32'h0000_CAFE);
    checkOutput("postreset_rd_addr", 32'(rd_addr_out), 32'd7);
    @(negedge clk_in);
    runOp(INST_LHU, 32'h40, 32'h0, 32'h0, 5'd17, -1, 0, 1'b0, 1'b1, 32'h0000_FFFE);

    $display("[TB] randomized sequence");
    for (int i = 0; i < 80; i++) begin
      t = kinds[$urandom_range(0, 10)];
      runOp(t, 32'($urandom_range(0, 1019)), $urandom, $urandom, 5'($urandom),
            -1, 0, 1'b1, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
